tx_source_sequencer: RTL
========================

// Module: tx_source_sequencer
// PURPOSE
//  Sequences switching of one DVI TX port between the rx0/rx1 decoders.
//  Debounces the board switch and drives the BUFGMUX select and data-mux select.
//  Holds the TX PLL in reset across every clock change, waits for BUFPLL lock, then releases video.
//  Sits in the top level; one instance per TX port, all in the clk25 domain.
// PARAMETERS
//  DEBOUNCE_CYC  250000  cycles the synchronised switch must be stable before it is accepted (10 ms @ 25 MHz)
//  RST_CYC       16      minimum pll_reset pulse width, in cycles
//  LOCK_TMO      65535   cycles allowed in WAIT_LOCK before a retry
//  SETTLE_CYC    1024    cycles after lock before blank is released
// PORTS
//  clk25        in   1  25 MHz system clock
//  rstbtn_n     in   1  asynchronous active-low reset
//  sw_async     in   1  raw slide switch: 0 = rx0, 1 = rx1
//  rx0_ready    in   1  rx0 decoder usable (~rx0_reset); asynchronous
//  rx1_ready    in   1  rx1 decoder usable (~rx1_reset); asynchronous
//  tx_lock      in   1  TX BUFPLL LOCK; asynchronous
//  sel          out  1  source select to the BUFGMUX S input and to the data muxes
//  pll_reset    out  1  TX PLL_BASE RST
//  blank        out  1  forces tx de = 0 and RGB = 0 in the top level
//  active       out  1  high only in RUN
//  err_cnt      out  8  saturating count of lock timeouts plus lock losses
// BEHAVIOUR
//  Reset (async on rstbtn_n low; all outputs registered):
//   sel=0, pll_reset=1, blank=1, active=0, err_cnt=0, state=ASSERT_RST, debounced switch=0.
//  Synchronisation:
//   sw_async, rx0_ready, rx1_ready and tx_lock each pass through a 2-flop synchroniser.
//   Input-to-FSM latency is 2 cycles.
//  Debounce:
//   Counter clears on any change of the synchronised switch.
//   When the counter reaches DEBOUNCE_CYC-1, sw_db takes the switch value.
//   req = (sw_db != sel).
//  FSM states: ASSERT_RST, WAIT_LOCK, SETTLE, RUN.
//   ASSERT_RST
//    - pll_reset=1, blank=1.
//    - On entry with req, sel<=sw_db; sel changes only in this state, while the PLL is held in reset.
//    - Counts RST_CYC cycles, then goes to WAIT_LOCK once the selected rx_ready is 1.
//    - If rx_ready stays low, stays here with no timeout.
//   WAIT_LOCK
//    - pll_reset=0, blank=1.
//    - tx_lock=1 -> SETTLE.
//    - LOCK_TMO cycles elapse -> ASSERT_RST and err_cnt+1.
//   SETTLE
//    - pll_reset=0, blank=1.
//    - After SETTLE_CYC cycles with tx_lock held -> RUN.
//    - tx_lock drop -> ASSERT_RST, no error counted.
//   RUN
//    - pll_reset=0, blank=0, active=1.
//    - tx_lock drop -> ASSERT_RST and err_cnt+1.
//    - Selected rx_ready drop -> ASSERT_RST, no error counted.
//   In WAIT_LOCK, SETTLE or RUN, req=1 -> ASSERT_RST. This takes priority over every other transition in the same cycle.
//  Re-entry: every entry to ASSERT_RST reloads its counter.
//   A req arriving during ASSERT_RST updates sel and restarts the RST_CYC count.
//  Outputs on leaving RUN: blank and pll_reset assert in the same edge as the state change.
//  err_cnt saturates at 8'hFF; only reset clears it.
//  Counters are sized with $clog2 of their parameter and never wrap; each counter is held once its terminal value is reached.
//  A reset asserted mid-sequence returns all outputs to their reset values immediately (asynchronously).
// STRUCTURE
//  Shared package dvi_ctl_pkg: FSM state localparams (2-bit encoding) and the ERR_W=8 constant.
//  One sub-module: the existing synchro cell, instantiated 4x with INITIALIZE("LOGIC0").
//  FSM, debounce counter and timers stay inline in this module.
// TESTING (DEBOUNCE_CYC=8, RST_CYC=4, LOCK_TMO=32, SETTLE_CYC=4)
//  1. Bring-up: release reset with rx0_ready=1, tx_lock rising 10 cycles after pll_reset falls.
//     -> pll_reset high >= 4 cycles; active=1 and blank=0 after 4 settle cycles; sel=0; err_cnt=0.
//  2. Bounce: toggle sw_async every 3 cycles for 40 cycles, then hold it at 1.
//     -> sel stays 0 during the bouncing.
//     -> sel=1 appears exactly 2+8 cycles after the hold, with pll_reset=1 in that same cycle.
//  3. Lock timeout: hold tx_lock=0.
//     -> Every 4+32 cycles the FSM re-enters ASSERT_RST; err_cnt=1,2,3...
//     -> With more than 255 timeouts, err_cnt stays at 8'hFF.
//  4. Source not ready: switch to rx1 while rx1_ready=0.
//     -> pll_reset held high indefinitely, blank=1, err_cnt unchanged.
//     -> Raising rx1_ready gives pll_reset=0 after 2 sync cycles plus the remaining RST count.
//  5. Switch during SETTLE: change sw_async in SETTLE.
//     -> Returns to ASSERT_RST, sel flips, full RST_CYC pulse restarts, no error counted.
//  6. Lock loss in RUN: drop tx_lock.
//     -> Within 3 cycles, blank=1, active=0, pll_reset=1, err_cnt+1.
//     -> Assert rstbtn_n=0 mid-WAIT_LOCK: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/dvi_ctl_pkg.sv
// Shared definitions for the DVI TX control blocks: FSM state encoding and counter widths.
package dvi_ctl_pkg;

  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    StAssertRst = 2'd0,
    StWaitLock  = 2'd1,
    StSettle    = 2'd2,
    StRun       = 2'd3
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/synchro.sv
// Two-flop synchroniser for a single asynchronous level; INITIALIZE picks the reset level.
module synchro #(
  parameter string INITIALIZE = "LOGIC0"
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  localparam logic InitVal = (INITIALIZE == "LOGIC1") ? 1'b1 : 1'b0;

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {2{InitVal}};
    end else begin
      ff_q <= {ff_q[0], async_i};
    end
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/tx_source_sequencer.sv
// Switches one DVI TX port between rx0/rx1: debounces the switch, holds the TX PLL in reset
// across every clock change, waits for lock and settle, then releases video.
module tx_source_sequencer
  import dvi_ctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned RST_CYC      = 16,
  parameter int unsigned LOCK_TMO     = 65535,
  parameter int unsigned SETTLE_CYC   = 1024
) (
  input  logic             clk25,
  input  logic             rstbtn_n,
  input  logic             sw_async,
  input  logic             rx0_ready,
  input  logic             rx1_ready,
  input  logic             tx_lock,
  output logic             sel,
  output logic             pll_reset,
  output logic             blank,
  output logic             active,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned DbW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TmrMax = max3(RST_CYC, LOCK_TMO, SETTLE_CYC);
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [DbW-1:0]   DbLast     = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [TmrW-1:0]  RstLast    = TmrW'(RST_CYC - 1);
  localparam logic [TmrW-1:0]  LockLast   = TmrW'(LOCK_TMO - 1);
  localparam logic [TmrW-1:0]  SettleLast = TmrW'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ErrMax     = {ERR_W{1'b1}};

  logic sw_s, rx0_s, rx1_s, lock_s;

  synchro #(.INITIALIZE("LOGIC0")) u_sync_sw (
    .clk_i(clk25), .rst_ni(rstbtn_n), .async_i(sw_async), .sync_o(sw_s)
  );
  synchro #(.INITIALIZE("LOGIC0")) u_sync_rx0 (
    .clk_i(clk25), .rst_ni(rstbtn_n), .async_i(rx0_ready), .sync_o(rx0_s)
  );
  synchro #(.INITIALIZE("LOGIC0")) u_sync_rx1 (
    .clk_i(clk25), .rst_ni(rstbtn_n), .async_i(rx1_ready), .sync_o(rx1_s)
  );
  synchro #(.INITIALIZE("LOGIC0")) u_sync_lock (
    .clk_i(clk25), .rst_ni(rstbtn_n), .async_i(tx_lock), .sync_o(lock_s)
  );

  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             sw_last_q, sw_last_d;
  logic             sw_db_q, sw_db_d;
  logic             sel_q, sel_d;
  logic             pll_reset_q, pll_reset_d;
  logic             blank_q, blank_d;
  logic             active_q, active_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             req, rdy_sel, err_inc;

  // Debounce: the counter restarts whenever the synchronised switch moves.
  always_comb begin
    sw_last_d = sw_s;
    db_cnt_d  = db_cnt_q;
    sw_db_d   = sw_db_q;
    if (sw_s != sw_last_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DbLast) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (db_cnt_d == DbLast) begin
      sw_db_d = sw_s;
    end
  end

  assign req     = (sw_db_q != sel_q);
  assign rdy_sel = sel_q ? rx1_s : rx0_s;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    err_inc = 1'b0;
    unique case (state_q)
      StAssertRst: begin
        if (tmr_q != RstLast) begin
          tmr_d = tmr_q + 1'b1;
        end else if (rdy_sel) begin
          state_d = StWaitLock;
          tmr_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StSettle;
          tmr_d   = '0;
        end else if (tmr_q == LockLast) begin
          state_d = StAssertRst;
          tmr_d   = '0;
          err_inc = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StSettle: begin
        if (!lock_s) begin
          state_d = StAssertRst;
          tmr_d   = '0;
        end else if (tmr_q == SettleLast) begin
          state_d = StRun;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StAssertRst;
          tmr_d   = '0;
          err_inc = 1'b1;
        end else if (!rdy_sel) begin
          state_d = StAssertRst;
          tmr_d   = '0;
        end
      end
    endcase
    // A pending switch request overrides everything; sel only moves while the PLL is in reset.
    if (req) begin
      state_d = StAssertRst;
      tmr_d   = '0;
      sel_d   = sw_db_q;
      err_inc = 1'b0;
    end
    err_d       = (err_inc && (err_q != ErrMax)) ? err_q + 1'b1 : err_q;
    pll_reset_d = (state_d == StAssertRst);
    blank_d     = (state_d != StRun);
    active_d    = (state_d == StRun);
  end

  always_ff @(posedge clk25 or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q     <= StAssertRst;
      tmr_q       <= '0;
      db_cnt_q    <= '0;
      sw_last_q   <= 1'b0;
      sw_db_q     <= 1'b0;
      sel_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      blank_q     <= 1'b1;
      active_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      db_cnt_q    <= db_cnt_d;
      sw_last_q   <= sw_last_d;
      sw_db_q     <= sw_db_d;
      sel_q       <= sel_d;
      pll_reset_q <= pll_reset_d;
      blank_q     <= blank_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign pll_reset = pll_reset_q;
  assign blank     = blank_q;
  assign active    = active_q;
  assign err_cnt   = err_q;

endmodule
